seg_hex_reader: RTL and testbench

- Reverse direction of the hex-to-7-segment path: samples a multiplexed 7-segment drive bus (segment lines plus one-hot digit enables) and reconstructs the hex nibble shown on each digit.
- Sits on the display bus as a readback/self-check monitor. Flags undecodable patterns and pulses when a complete frame of all digits has been read.

---
 rtl/seg_hex_reader.sv | 148 ++++++++++++++
 tb/tb_seg_hex_reader.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_hex_reader.sv
// Readback monitor for a multiplexed 7-segment bus: recovers the hex nibble shown
// on each digit, flags undecodable patterns and pulses once a full frame is read.
module seg_hex_reader #(
  parameter  int unsigned DIGITS        = 4,
  parameter  int unsigned STABLE_CYCLES = 3,
  localparam int unsigned ERR_W         = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_en,
  output logic [4*DIGITS-1:0]   hex_out,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  frame_valid,
  output logic                  code_err,
  output logic [ERR_W-1:0]      err_digit
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);

  logic [DIGITS-1:0]   r_prev_sel;
  logic [6:0]          r_prev_seg;
  logic [CNT_W-1:0]    r_cnt;
  logic [DIGITS-1:0]   r_seen;
  logic [4*DIGITS-1:0] r_hex;
  logic [DIGITS-1:0]   r_dv;
  logic                r_fv;
  logic                r_ce;
  logic [ERR_W-1:0]    r_err;

  logic                w_same;
  logic                w_onehot;
  logic                w_capture;
  logic [4:0]          w_dec;
  logic [ERR_W-1:0]    w_idx;
  logic [DIGITS-1:0]   w_seen_or;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [DIGITS-1:0]   w_seen_nxt;
  logic [4*DIGITS-1:0] w_hex_nxt;
  logic [DIGITS-1:0]   w_dv_nxt;
  logic                w_fv_nxt;
  logic                w_ce_nxt;
  logic [ERR_W-1:0]    w_err_nxt;

  // Inverse of the hex_display encoding; bit 4 of the result marks a legal pattern.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    logic [4:0] res;
    res = 5'b0_0000;
    case (seg)
      7'b1111110: res = 5'h10;
      7'b0110000: res = 5'h11;
      7'b1101101: res = 5'h12;
      7'b1111001: res = 5'h13;
      7'b0110011: res = 5'h14;
      7'b1011011: res = 5'h15;
      7'b1011111: res = 5'h16;
      7'b1110000: res = 5'h17;
      7'b1111111: res = 5'h18;
      7'b1111011: res = 5'h19;
      7'b1110111: res = 5'h1A;
      7'b0011111: res = 5'h1B;
      7'b1001110: res = 5'h1C;
      7'b0111101: res = 5'h1D;
      7'b1001111: res = 5'h1E;
      7'b1000111: res = 5'h1F;
      default:    res = 5'b0_0000;
    endcase
    return res;
  endfunction

  assign w_same    = ({dig_en, seg_in} == {r_prev_sel, r_prev_seg});
  assign w_onehot  = (dig_en != '0) && ((dig_en & (dig_en - DIGITS'(1))) == '0);
  assign w_capture = w_same && (r_cnt == CNT_W'(STABLE_CYCLES - 1)) && w_onehot;
  assign w_dec     = decode_seg(seg_in);
  assign w_seen_or = r_seen | dig_en;

  // Saturating dwell counter; the capture point is crossed exactly once per dwell.
  assign w_cnt_nxt = !w_same                             ? CNT_W'(1) :
                     (r_cnt == CNT_W'(STABLE_CYCLES))    ? r_cnt     :
                                                           r_cnt + CNT_W'(1);

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (dig_en[i]) w_idx = ERR_W'(i);
    end
  end

  // Slot, flag and frame-mask updates for a capture on the selected digit.
  always_comb begin
    w_hex_nxt  = r_hex;
    w_dv_nxt   = r_dv;
    w_seen_nxt = r_seen;
    w_fv_nxt   = 1'b0;
    w_ce_nxt   = 1'b0;
    w_err_nxt  = r_err;
    if (w_capture) begin
      if (w_dec[4]) begin
        for (int i = 0; i < int'(DIGITS); i++) begin
          if (dig_en[i]) w_hex_nxt[4*i +: 4] = w_dec[3:0];
        end
        w_dv_nxt = r_dv | dig_en;
        if (&w_seen_or) begin
          w_fv_nxt   = 1'b1;
          w_seen_nxt = '0;
        end else begin
          w_seen_nxt = w_seen_or;
        end
      end else begin
        w_ce_nxt   = 1'b1;
        w_err_nxt  = w_idx;
        w_dv_nxt   = r_dv & ~dig_en;
        w_seen_nxt = r_seen & ~dig_en;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_sel <= '0;
      r_prev_seg <= '0;
      r_cnt      <= '0;
      r_seen     <= '0;
      r_hex      <= '0;
      r_dv       <= '0;
      r_fv       <= 1'b0;
      r_ce       <= 1'b0;
      r_err      <= '0;
    end else begin
      r_prev_sel <= dig_en;
      r_prev_seg <= seg_in;
      r_cnt      <= w_cnt_nxt;
      r_seen     <= w_seen_nxt;
      r_hex      <= w_hex_nxt;
      r_dv       <= w_dv_nxt;
      r_fv       <= w_fv_nxt;
      r_ce       <= w_ce_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign hex_out     = r_hex;
  assign digit_valid = r_dv;
  assign frame_valid = r_fv;
  assign code_err    = r_ce;
  assign err_digit   = r_err;

endmodule

// File: tb/tb_seg_hex_reader.sv
// Scoreboard bench for seg_hex_reader: a dwell-length reference model predicts every
// cycle's outputs, a separate monitor compares them; directed checks pin key values.
module tb_seg_hex_reader;

  localparam int unsigned D  = 4;
  localparam int unsigned S  = 3;
  localparam int unsigned EW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [6:0]     seg_in;
  logic [D-1:0]   dig_en;
  logic [4*D-1:0] hex_out;
  logic [D-1:0]   digit_valid;
  logic           frame_valid;
  logic           code_err;
  logic [EW-1:0]  err_digit;

  seg_hex_reader #(.DIGITS(D), .STABLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dig_en(dig_en),
    .hex_out(hex_out), .digit_valid(digit_valid), .frame_valid(frame_valid),
    .code_err(code_err), .err_digit(err_digit)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4*D-1:0] hex;
    logic [D-1:0]   dv;
    logic           fv;
    logic           ce;
    logic [EW-1:0]  ed;
  } obs_t;

  obs_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   fv_seen  = 0;
  int   ce_seen  = 0;

  logic [6:0] pat [16];

  int         m_nib [D];
  bit         m_dv  [D];
  bit         m_seen[D];
  int         m_err;
  int         m_run;
  logic [D-1:0] m_psel;
  logic [6:0]   m_pseg;

  function automatic int find_pat(input logic [6:0] s);
    for (int i = 0; i < 16; i++) if (pat[i] == s) return i;
    return -1;
  endfunction

  // Capture happens when a sample has been seen S times in a row on exactly one digit.
  task automatic model_step(input bit rst, input logic [D-1:0] sel, input logic [6:0] seg,
                            output obs_t o);
    bit fv, ce, full;
    int ones, idx, code;
    fv = 0; ce = 0; ones = 0; idx = 0;
    if (!rst) begin
      for (int i = 0; i < int'(D); i++) begin m_nib[i] = 0; m_dv[i] = 0; m_seen[i] = 0; end
      m_err = 0; m_run = 0; m_psel = '0; m_pseg = '0;
    end else begin
      if (sel == m_psel && seg == m_pseg) m_run++;
      else m_run = 1;
      m_psel = sel; m_pseg = seg;
      for (int i = 0; i < int'(D); i++) if (sel[i]) begin ones++; idx = i; end
      if (m_run == int'(S) && ones == 1) begin
        code = find_pat(seg);
        if (code >= 0) begin
          m_nib[idx] = code; m_dv[idx] = 1; m_seen[idx] = 1;
          full = 1;
          for (int i = 0; i < int'(D); i++) if (!m_seen[i]) full = 0;
          if (full) begin
            fv = 1;
            for (int i = 0; i < int'(D); i++) m_seen[i] = 0;
          end
        end else begin
          ce = 1; m_err = idx; m_dv[idx] = 0; m_seen[idx] = 0;
        end
      end
    end
    for (int i = 0; i < int'(D); i++) begin
      o.hex[4*i +: 4] = 4'(m_nib[i]);
      o.dv[i]         = m_dv[i];
    end
    o.fv = fv;
    o.ce = ce;
    o.ed = EW'(m_err);
  endtask

  task automatic drive(input bit rst, input logic [D-1:0] sel, input logic [6:0] seg,
                       input int n);
    obs_t o;
    repeat (n) begin
      rst_n  = rst;
      dig_en = sel;
      seg_in = seg;
      model_step(rst, sel, seg, o);
      exp_q.push_back(o);
      @(negedge clk);
    end
  endtask

  task automatic dchk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, expv, $time);
    end
  endtask

  // Monitor: one expected observation per clock edge.
  initial begin : monitor
    obs_t e;
    obs_t a;
    forever begin
      @(posedge clk);
      #1;
      if (frame_valid === 1'b1) fv_seen++;
      if (code_err === 1'b1) ce_seen++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {hex_out, digit_valid, frame_valid, code_err, err_digit};
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL scoreboard @%0t: got hex=%h dv=%b fv=%b ce=%b ed=%0d, expected hex=%h dv=%b fv=%b ce=%b ed=%0d",
                   $time, a.hex, a.dv, a.fv, a.ce, a.ed, e.hex, e.dv, e.fv, e.ce, e.ed);
        end
      end
    end
  end

  initial begin : stim
    int f0, c0, dwell;
    logic [D-1:0] sel;
    logic [6:0]   seg;
    obs_t         o;
    pat[0]  = 7'b1111110; pat[1]  = 7'b0110000; pat[2]  = 7'b1101101; pat[3]  = 7'b1111001;
    pat[4]  = 7'b0110011; pat[5]  = 7'b1011011; pat[6]  = 7'b1011111; pat[7]  = 7'b1110000;
    pat[8]  = 7'b1111111; pat[9]  = 7'b1111011; pat[10] = 7'b1110111; pat[11] = 7'b0011111;
    pat[12] = 7'b1001110; pat[13] = 7'b0111101; pat[14] = 7'b1001111; pat[15] = 7'b1000111;
    rst_n = 1'b0; dig_en = '0; seg_in = '0;
    model_step(1'b0, '0, '0, o);
    @(negedge clk);

    // Reset and first capture latency
    drive(1'b0, 4'b0001, 7'b1111111, 3);
    dchk("reset_hex", 32'(hex_out), 32'h0);
    dchk("reset_flags", 32'({digit_valid, frame_valid, code_err, err_digit}), 32'h0);
    drive(1'b1, 4'b0001, 7'b1111111, 2);
    dchk("pre_capture_dv", 32'(digit_valid), 32'h0);
    drive(1'b1, 4'b0001, 7'b1111111, 1);
    dchk("first_capture_hex", 32'(hex_out), 32'h0008);
    dchk("first_capture_dv", 32'(digit_valid), 32'h1);

    // Full scan F,3,A,1
    f0 = fv_seen;
    drive(1'b1, 4'b0001, pat[15], 5);
    drive(1'b1, 4'b0010, pat[3], 5);
    drive(1'b1, 4'b0100, pat[10], 5);
    drive(1'b1, 4'b1000, pat[1], 3);
    dchk("scan_frame_pulse", 32'(frame_valid), 32'h1);
    drive(1'b1, 4'b1000, pat[1], 2);
    dchk("scan_hex", 32'(hex_out), 32'h1A3F);
    dchk("scan_dv", 32'(digit_valid), 32'hF);
    dchk("scan_frame_count", 32'(fv_seen - f0), 32'h1);

    // Glitch rejection then clean dwell
    drive(1'b1, 4'b0001, pat[1], 2);
    drive(1'b1, 4'b0000, 7'b1111110, 2);
    dchk("glitch_hex", 32'(hex_out), 32'h1A3F);
    drive(1'b1, 4'b0001, pat[1], 3);
    dchk("dwell3_hex", 32'(hex_out), 32'h1A31);

    // Bad code on digit 2, frame held until digit 2 recaptured
    c0 = ce_seen; f0 = fv_seen;
    drive(1'b1, 4'b0100, 7'b0000001, 4);
    dchk("bad_ce_count", 32'(ce_seen - c0), 32'h1);
    dchk("bad_err_digit", 32'(err_digit), 32'h2);
    dchk("bad_dv", 32'(digit_valid), 32'hB);
    dchk("bad_hex", 32'(hex_out), 32'h1A31);
    drive(1'b1, 4'b0010, pat[3], 4);
    drive(1'b1, 4'b1000, pat[10], 4);
    dchk("bad_no_frame", 32'(fv_seen - f0), 32'h0);
    drive(1'b1, 4'b0100, pat[5], 4);
    dchk("recapture_frame", 32'(fv_seen - f0), 32'h1);
    dchk("recapture_hex", 32'(hex_out), 32'hA531);

    // Illegal selects
    c0 = ce_seen; f0 = fv_seen;
    drive(1'b1, 4'b0000, pat[0], 10);
    drive(1'b1, 4'b0110, pat[0], 10);
    dchk("illegal_hex", 32'(hex_out), 32'hA531);
    dchk("illegal_dv", 32'(digit_valid), 32'hF);
    dchk("illegal_pulses", 32'((fv_seen - f0) + (ce_seen - c0)), 32'h0);

    // Reset mid-frame
    f0 = fv_seen;
    drive(1'b1, 4'b0001, pat[5], 4);
    drive(1'b1, 4'b0010, pat[6], 4);
    drive(1'b0, 4'b0010, pat[6], 1);
    drive(1'b1, 4'b0100, pat[7], 4);
    drive(1'b1, 4'b1000, pat[9], 4);
    dchk("midreset_no_frame", 32'(fv_seen - f0), 32'h0);
    dchk("midreset_hex", 32'(hex_out), 32'h9700);
    dchk("midreset_dv", 32'(digit_valid), 32'hC);

    // Randomized traffic
    repeat (300) begin
      dwell = $urandom_range(1, 6);
      if ($urandom_range(0, 99) < 85) sel = D'(1) << $urandom_range(0, D - 1);
      else sel = D'($urandom);
      if ($urandom_range(0, 99) < 80) seg = pat[$urandom_range(0, 15)];
      else seg = 7'($urandom);
      if ($urandom_range(0, 99) < 2) drive(1'b0, sel, seg, 1);
      drive(1'b1, sel, seg, dwell);
    end

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
